lbist_ctrl: RTL and testbench

- Sequencing controller for one logic-BIST session.
- Seeds the pseudo-random pattern generator and steps it once per pattern, with a programmable settle time before each capture.
- Compacts circuit-under-test responses into an internal MISR.
- After the programmed pattern count, compares the signature against a golden value and reports done/pass to the test-access logic.

---
 rtl/lbist_pkg.sv | 16 +
 rtl/lbist_misr.sv | 34 +++
 rtl/lbist_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lbist_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lbist_pkg.sv
// Types and constants shared by the logic-BIST controller and its signature compactor.
package lbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_CAPTURE,
    ST_COMPARE,
    ST_DONE
  } lbist_state_e;

  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
  localparam int unsigned SETTLE_MIN    = 1;

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register compacting CUT responses, one shift per enabled cycle.
module lbist_misr #(
  parameter int unsigned           RESP_W    = 16,
  parameter logic [RESP_W-1:0]     MISR_POLY = RESP_W'(16'h1021)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [RESP_W-1:0] sig
);

  logic [RESP_W-1:0] sig_q;
  logic [RESP_W-1:0] sig_d;

  // Shift left, fold in the response, apply feedback when the MSB falls out.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[RESP_W-2:0], 1'b0} ^ din ^ (sig_q[RESP_W-1] ? MISR_POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST session sequencer: seeds/steps the pattern generator, compacts responses,
// and checks the final signature against a golden value.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned       PAT_W     = 16,
  parameter int unsigned       RESP_W    = 16,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       SETTLE    = 2,
  parameter logic [RESP_W-1:0] MISR_POLY = RESP_W'(MISR_POLY_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  seed,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [RESP_W-1:0] golden,
  input  logic [RESP_W-1:0] cut_resp,
  output logic [PAT_W-1:0]  gen_seed,
  output logic              gen_load,
  output logic              gen_step,
  output logic              pattern_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature,
  output logic [CNT_W-1:0]  pattern_count
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < SETTLE_MIN) begin : g_bad_settle
    $error("lbist_ctrl: SETTLE must be at least 1");
  end

  lbist_state_e      state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  npat_q, npat_d;
  logic [RESP_W-1:0] golden_q, golden_d;
  logic [PAT_W-1:0]  seed_q, seed_d;
  logic              pass_q, pass_d;
  logic              gen_load_q, gen_load_d;
  logic              gen_step_q, gen_step_d;
  logic              pvalid_q, pvalid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              misr_clr, misr_en;
  logic [CNT_W-1:0]  cnt_inc;
  logic [RESP_W-1:0] sig;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state, datapath updates and registered-output decode.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    npat_d     = npat_q;
    golden_d   = golden_q;
    seed_d     = seed_q;
    pass_d     = pass_q;
    misr_clr   = 1'b0;
    misr_en    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          seed_d   = seed;
          npat_d   = num_patterns;
          golden_d = golden;
          cnt_d    = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        settle_d = '0;
        state_d  = (npat_q == '0) ? ST_COMPARE : ST_APPLY;
      end
      ST_APPLY: begin
        if (settle_q == SET_W'(SETTLE - 1)) state_d = ST_CAPTURE;
        else                                settle_d = settle_q + SET_W'(1);
      end
      ST_CAPTURE: begin
        misr_en  = 1'b1;
        cnt_d    = cnt_inc;
        settle_d = '0;
        state_d  = (cnt_inc == npat_q) ? ST_COMPARE : ST_APPLY;
      end
      ST_COMPARE: begin
        pass_d  = (sig == golden_q);
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start; results are frozen.
    if (abort) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      cnt_d    = cnt_q;
      npat_d   = npat_q;
      golden_d = golden_q;
      seed_d   = '0;
      pass_d   = 1'b0;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
    end

    gen_load_d = (state_d == ST_LOAD);
    gen_step_d = (state_d == ST_CAPTURE);
    pvalid_d   = (state_d == ST_APPLY) || (state_d == ST_CAPTURE);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_APPLY) ||
                 (state_d == ST_CAPTURE) || (state_d == ST_COMPARE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      cnt_q      <= '0;
      npat_q     <= '0;
      golden_q   <= '0;
      seed_q     <= '0;
      pass_q     <= 1'b0;
      gen_load_q <= 1'b0;
      gen_step_q <= 1'b0;
      pvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      npat_q     <= npat_d;
      golden_q   <= golden_d;
      seed_q     <= seed_d;
      pass_q     <= pass_d;
      gen_load_q <= gen_load_d;
      gen_step_q <= gen_step_d;
      pvalid_q   <= pvalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  lbist_misr #(
    .RESP_W    (RESP_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (cut_resp),
    .sig   (sig)
  );

  assign gen_seed      = seed_q;
  assign gen_load      = gen_load_q;
  assign gen_step      = gen_step_q;
  assign pattern_valid = pvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign signature     = sig;
  assign pattern_count = cnt_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Randomized bench for lbist_ctrl against a cycle-offset timeline model and a MISR model.
module tb_lbist_ctrl;

  localparam int unsigned PAT_W  = 16;
  localparam int unsigned RESP_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SETTLE = 2;
  localparam logic [15:0] POLY   = 16'h1021;
  localparam int          P      = SETTLE + 1;
  localparam int          MAXN   = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [PAT_W-1:0]  seed;
  logic [CNT_W-1:0]  num_patterns;
  logic [RESP_W-1:0] golden;
  logic [RESP_W-1:0] cut_resp;
  logic [PAT_W-1:0]  gen_seed;
  logic              gen_load, gen_step, pattern_valid, busy, done, pass;
  logic [RESP_W-1:0] signature;
  logic [CNT_W-1:0]  pattern_count;

  int checks = 0;
  int errors = 0;

  lbist_ctrl #(
    .PAT_W     (PAT_W),
    .RESP_W    (RESP_W),
    .CNT_W     (CNT_W),
    .SETTLE    (SETTLE),
    .MISR_POLY (POLY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .seed          (seed),
    .num_patterns  (num_patterns),
    .golden        (golden),
    .cut_resp      (cut_resp),
    .gen_seed      (gen_seed),
    .gen_load      (gen_load),
    .gen_step      (gen_step),
    .pattern_valid (pattern_valid),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .pattern_count (pattern_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] fb;
    fb = s[15] ? POLY : 16'h0;
    return (s << 1) ^ d ^ fb;
  endfunction

  // Expected {gen_load, gen_step, pattern_valid, busy, done} j cycles after the start edge.
  function automatic logic [4:0] exp_flags(input int j, input int n);
    int last;
    last = n * P;
    if (j == 0)             return 5'b10010;
    else if (j <= last)     return (j % P == 0) ? 5'b01110 : 5'b00110;
    else if (j == last + 1) return 5'b00010;
    else                    return 5'b00001;
  endfunction

  function automatic int exp_cnt(input int j, input int n);
    int c;
    if (j == 0) return 0;
    c = (j - 1) / P;
    return (c > n) ? n : c;
  endfunction

  function automatic logic [4:0] flags();
    return {gen_load, gen_step, pattern_valid, busy, done};
  endfunction

  task automatic check_idle(input string tag, input int cnt, input logic [15:0] sig);
    check({tag, "_flags"}, 32'(flags()), 32'(5'b0));
    check({tag, "_pass"},  32'(pass), 32'(1'b0));
    check({tag, "_seed"},  32'(gen_seed), 32'(0));
    check({tag, "_cnt"},   32'(pattern_count), 32'(cnt));
    check({tag, "_sig"},   32'(signature), 32'(sig));
  endtask

  // One session starting at a negedge; optional mid-run start poke, abort+start, or reset.
  task automatic run_session(input logic [15:0] sd, input int n, input int gmode,
                             input int poke_j, input int abort_j, input int reset_j,
                             input bit const_resp);
    logic [15:0] resp [MAXN];
    logic [15:0] msig [MAXN+1];
    logic [15:0] gval;
    logic        exp_pass;
    int          last, endj, c;
    msig[0] = 16'h0;
    for (int p = 0; p < n; p++) begin
      resp[p]   = const_resp ? 16'h0001 : 16'($urandom);
      msig[p+1] = misr_model(msig[p], resp[p]);
    end
    gval     = (gmode == 0) ? msig[n] : (gmode == 1) ? (msig[n] ^ 16'h1) : 16'($urandom);
    exp_pass = (gval == msig[n]);
    last     = n * P;
    endj     = last + 2;

    start        = 1'b1;
    seed         = sd;
    num_patterns = CNT_W'(n);
    golden       = gval;
    cut_resp     = const_resp ? 16'h0001 : 16'($urandom);
    @(posedge clk);
    for (int j = 0; j <= endj; j++) begin
      @(negedge clk);
      start        = 1'b0;
      abort        = 1'b0;
      seed         = 16'($urandom);
      num_patterns = CNT_W'($urandom);
      golden       = 16'($urandom);
      c = exp_cnt(j, n);
      check("flags", 32'(flags()), 32'(exp_flags(j, n)));
      check("cnt",   32'(pattern_count), 32'(c));
      check("sig",   32'(signature), 32'(msig[c]));
      check("seed",  32'(gen_seed), 32'(sd));
      check("pass",  32'(pass), 32'((j == endj) ? exp_pass : 1'b0));
      if (j == endj) return;
      if (j >= 1 && j <= last && (j % P) == 0) cut_resp = resp[j / P - 1];
      else cut_resp = const_resp ? 16'h0001 : 16'($urandom);
      if (j == poke_j) start = 1'b1;
      if (j == abort_j) begin
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort", c, msig[c]);
        repeat (2) @(negedge clk);
        check_idle("abort_hold", c, msig[c]);
        return;
      end
      if (j == reset_j) begin
        reset = 1'b1;
        #1;
        check_idle("rst_async", 0, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        check_idle("rst_hold", 0, 16'h0);
        return;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    seed         = '0;
    num_patterns = '0;
    golden       = '0;
    cut_resp     = '0;
    repeat (3) @(negedge clk);
    check_idle("reset", 0, 16'h0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset", 0, 16'h0);

    // directed: constant response, golden right then wrong
    run_session(16'hACE1, 3, 0, -1, -1, -1, 1'b1);
    run_session(16'h1234, 3, 1, -1, -1, -1, 1'b1);
    // zero patterns with golden 0
    run_session(16'h5555, 0, 0, -1, -1, -1, 1'b0);
    // start poked mid-APPLY is ignored
    run_session(16'hBEEF, 4, 0, 2, -1, -1, 1'b0);
    // abort together with start during capture of pattern 2
    run_session(16'hC0DE, 4, 0, -1, 2 * P, -1, 1'b0);
    run_session(16'h0F0F, 2, 0, -1, -1, -1, 1'b0);
    // reset mid-APPLY, then a clean session
    run_session(16'h7777, 5, 0, -1, -1, 2, 1'b0);
    run_session(16'h8888, 3, 0, -1, -1, -1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int n;
      int pk;
      n  = int'($urandom_range(0, 12));
      pk = ($urandom_range(0, 2) == 0 && n > 0) ? int'($urandom_range(1, n * P)) : -1;
      run_session(16'($urandom), n, int'($urandom_range(0, 2)), pk, -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
